// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD 7-segment display block.
// Purely declarative; segment codes are active-low {g,f,e,d,c,b,a}; no handshake, always accepted.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_DASH;
    if (digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg7_display_if.sv
// PIO-side bundle for the display block; blink_mask exists only with BCD_DISP_BLINK_EN.
// No latency of its own; no backpressure (display always accepts the PIO word).
interface bcd_seg7_display_if #(
  parameter int DIGITS = 3
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                blank_lz;
`ifdef BCD_DISP_BLINK_EN
  logic [DIGITS-1:0]   blink_mask;
`endif
  logic [7*DIGITS-1:0] hex_n;
  logic                update_pulse;
  logic                invalid;

`ifdef BCD_DISP_BLINK_EN
  modport master (output bcd_in, blank_lz, blink_mask, input hex_n, update_pulse, invalid);
  modport slave  (input bcd_in, blank_lz, blink_mask, output hex_n, update_pulse, invalid);
`else
  modport master (output bcd_in, blank_lz, input hex_n, update_pulse, invalid);
  modport slave  (input bcd_in, blank_lz, output hex_n, update_pulse, invalid);
`endif
endinterface

// File: rtl/bcd_seg7_display_seg7.sv
// Per-digit decoder: BCD digit plus blank request -> active-low segments.
// Combinational, zero latency; no backpressure.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = blank_i ? SEG_BLANK : bcd_to_seg(digit_i);

endmodule

// File: rtl/bcd_seg7_display.sv
// Debounced BCD-to-HEX display driver with leading-zero blanking; optional blink via BCD_DISP_BLINK_EN.
// Latency: held input reaches hex_n SETTLE_CYCLES+3 edges after it is presented; blank_lz/blink 1 cycle.
// No backpressure: input is sampled every cycle, changes restart the settle window.
module bcd_seg7_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int CLK_HZ        = 50000000,
  parameter int BLINK_HZ      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_seg7_display_if.slave       disp
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   shown_q, shown_d;
  logic [BCD_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit_q;
  logic [SEG_W-1:0]   hex_q, hex_d;
  logic               upd_q;
  logic               inv_q, inv_d;
  logic [DIGITS-1:0]  blank;
  logic [SEG_W-1:0]   seg_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shown_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any deviation from the candidate restarts the window; returning to shown abandons it.
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (disp.bcd_in != shown_q) begin
          state_d = SETTLE;
          cand_d  = disp.bcd_in;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (disp.bcd_in == shown_q) begin
          state_d = IDLE;
        end else if (disp.bcd_in != cand_q) begin
          cand_d = disp.bcd_in;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        shown_d = cand_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blank from the MS digit down while digits are zero; digit0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (shown_q[4*i +: 4] == 4'd0);
      blank[i] = disp.blank_lz && zero_run;
    end
  end

  always_comb begin
    inv_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      inv_d = inv_d | (shown_q[4*i +: 4] > 4'd9);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_seg7 u_dec (
      .digit_i (shown_q[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_n_o (seg_dec[7*g +: 7])
    );
  end

`ifdef BCD_DISP_BLINK_EN
  localparam int PRESC_MAX = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               phase_on_q, phase_on_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      phase_on_q <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      phase_on_q <= phase_on_d;
    end
  end

  always_comb begin
    presc_d    = presc_q + PRESC_W'(1);
    phase_on_d = phase_on_q;
    if (presc_q == PRESC_W'(PRESC_MAX)) begin
      presc_d    = '0;
      phase_on_d = ~phase_on_q;
    end
  end

  always_comb begin
    hex_d = seg_dec;
    for (int i = 0; i < DIGITS; i++) begin
      if (!phase_on_q && disp.blink_mask[i]) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end
    end
  end
`else
  assign hex_d = seg_dec;
`endif

  // commit_q delays the strobe so it lines up with the first cycle hex_n shows the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q    <= '1;
      inv_q    <= 1'b0;
      upd_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hex_q    <= hex_d;
      inv_q    <= inv_d;
      upd_q    <= commit_q;
      commit_q <= (state_q == COMMIT);
    end
  end

  assign disp.hex_n        = hex_q;
  assign disp.invalid      = inv_q;
  assign disp.update_pulse = upd_q;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Directed bench for bcd_seg7_display (SETTLE_CYCLES=4); blink scenario runs with BCD_DISP_BLINK_EN.
module tb_bcd_seg7_display;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  localparam logic [20:0] ALL_OFF = 21'h1FFFFF;
  localparam logic [20:0] H000    = {7'h40, 7'h40, 7'h40};
  localparam logic [20:0] H123    = {7'h79, 7'h24, 7'h30};
  localparam logic [20:0] H456    = {7'h19, 7'h12, 7'h02};

  bcd_seg7_display_if #(.DIGITS(3)) dif ();

  bcd_seg7_display #(
    .DIGITS        (3),
    .SETTLE_CYCLES (4),
    .CLK_HZ        (8),
    .BLINK_HZ      (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.bcd_in   = 12'h000;
    dif.blank_lz = 1'b0;
`ifdef BCD_DISP_BLINK_EN
    dif.blink_mask = 3'b000;
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (dif.hex_n !== ALL_OFF || dif.update_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d hex_n=%h pulse=%b want hex_n=%h pulse=0", k, dif.hex_n, dif.update_pulse, ALL_OFF);
      end
    end
    reset = 1'b0;
    tick();
    total++;
    if (dif.hex_n !== H000 || dif.invalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release hex_n=%h inv=%b want %h inv=0", dif.hex_n, dif.invalid, H000);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (dif.update_pulse !== 1'b0 || dif.hex_n !== H000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d hex_n=%h pulse=%b want %h pulse=0", k, dif.hex_n, dif.update_pulse, H000);
      end
    end
  endtask

  task automatic test_commit();
    tick();
    dif.bcd_in = 12'h123;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (k < 7) begin
        if (dif.hex_n !== H000 || dif.update_pulse !== 1'b0) begin
          bad++;
          $display("FAIL commit_early e0+%0d hex_n=%h pulse=%b want %h pulse=0", k, dif.hex_n, dif.update_pulse, H000);
        end
      end else if (k == 7) begin
        if (dif.hex_n !== H123 || dif.update_pulse !== 1'b1 || dif.invalid !== 1'b0) begin
          bad++;
          $display("FAIL commit_edge e0+7 hex_n=%h pulse=%b inv=%b want %h pulse=1 inv=0", dif.hex_n, dif.update_pulse, dif.invalid, H123);
        end
      end else begin
        if (dif.hex_n !== H123 || dif.update_pulse !== 1'b0) begin
          bad++;
          $display("FAIL commit_after e0+8 hex_n=%h pulse=%b want %h pulse=0", dif.hex_n, dif.update_pulse, H123);
        end
      end
    end
  endtask

  task automatic test_abort();
    tick();
    dif.bcd_in = 12'h124;
    tick();
    tick();
    dif.bcd_in = 12'h123;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (dif.hex_n !== H123 || dif.update_pulse !== 1'b0) begin
        bad++;
        $display("FAIL abort cyc=%0d hex_n=%h pulse=%b want %h pulse=0", k, dif.hex_n, dif.update_pulse, H123);
      end
    end
  endtask

  task automatic test_blanking();
    dif.blank_lz = 1'b1;
    dif.bcd_in   = 12'h007;
    repeat (8) tick();
    total++;
    if (dif.hex_n !== {7'h7F, 7'h7F, 7'h78} || dif.invalid !== 1'b0) begin
      bad++;
      $display("FAIL blank_007 hex_n=%h inv=%b want %h inv=0", dif.hex_n, dif.invalid, {7'h7F, 7'h7F, 7'h78});
    end
    dif.bcd_in = 12'h000;
    repeat (8) tick();
    total++;
    if (dif.hex_n !== {7'h7F, 7'h7F, 7'h40}) begin
      bad++;
      $display("FAIL blank_000 hex_n=%h want %h", dif.hex_n, {7'h7F, 7'h7F, 7'h40});
    end
    dif.bcd_in = 12'h0A5;
    repeat (8) tick();
    total++;
    if (dif.hex_n !== {7'h7F, 7'h3F, 7'h12} || dif.invalid !== 1'b1) begin
      bad++;
      $display("FAIL blank_0A5 hex_n=%h inv=%b want %h inv=1", dif.hex_n, dif.invalid, {7'h7F, 7'h3F, 7'h12});
    end
    dif.blank_lz = 1'b0;
    tick();
    total++;
    if (dif.hex_n !== {7'h40, 7'h3F, 7'h12} || dif.update_pulse !== 1'b0) begin
      bad++;
      $display("FAIL blank_off hex_n=%h pulse=%b want %h pulse=0", dif.hex_n, dif.update_pulse, {7'h40, 7'h3F, 7'h12});
    end
  endtask

  task automatic test_reset_mid_settle();
    tick();
    dif.bcd_in = 12'h456;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (dif.hex_n !== ALL_OFF || dif.update_pulse !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset hex_n=%h pulse=%b want %h pulse=0", dif.hex_n, dif.update_pulse, ALL_OFF);
    end
    reset = 1'b0;
    tick();
    total++;
    if (dif.hex_n !== H000 || dif.update_pulse !== 1'b0 || dif.invalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_after hex_n=%h pulse=%b inv=%b want %h pulse=0 inv=0", dif.hex_n, dif.update_pulse, dif.invalid, H000);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (k < 6) begin
        if (dif.hex_n !== H000 || dif.update_pulse !== 1'b0) begin
          bad++;
          $display("FAIL resettle_wait cyc=%0d hex_n=%h pulse=%b want %h pulse=0", k, dif.hex_n, dif.update_pulse, H000);
        end
      end else begin
        if (dif.hex_n !== H456 || dif.update_pulse !== 1'b1) begin
          bad++;
          $display("FAIL resettle_commit hex_n=%h pulse=%b want %h pulse=1", dif.hex_n, dif.update_pulse, H456);
        end
      end
    end
  endtask

`ifdef BCD_DISP_BLINK_EN
  task automatic test_blink();
    logic [6:0] d0;
    logic [6:0] prev;
    int         last_chg;
    int         n_chg;
    last_chg = -1;
    n_chg    = 0;
    prev     = 7'h00;
    dif.bcd_in     = 12'h123;
    dif.blink_mask = 3'b001;
    repeat (8) tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      d0 = dif.hex_n[6:0];
      total++;
      if ((d0 !== 7'h30 && d0 !== 7'h7F) || dif.hex_n[20:7] !== {7'h79, 7'h24}) begin
        bad++;
        $display("FAIL blink_value cyc=%0d hex_n=%h want %h or %h", k, dif.hex_n, H123, {7'h79, 7'h24, 7'h7F});
      end
      if (k > 0 && d0 !== prev) begin
        if (last_chg >= 0) begin
          total++;
          if (k - last_chg != 4) begin
            bad++;
            $display("FAIL blink_period cyc=%0d gap=%0d want 4", k, k - last_chg);
          end
        end
        last_chg = k;
        n_chg++;
      end
      prev = d0;
    end
    total++;
    if (n_chg < 5) begin
      bad++;
      $display("FAIL blink_toggles count=%0d want >=5", n_chg);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_commit();
    test_abort();
    test_blanking();
    test_reset_mid_settle();
`ifdef BCD_DISP_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
